lfsr_run_ctrl: RTL and testbench
================================

LFSR_RUN_CTRL -- requirements
Module: lfsr_run_ctrl

Interface
REQ-001 Parameter W, default 16, width of LFSR seed, run length and counter results.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request a test run; sampled only in IDLE.
REQ-005 abort  in  1  terminate the run in progress.
REQ-006 seed  in  W  LFSR seed; latched on an accepted start.
REQ-007 run_len  in  W  number of shift cycles; latched on an accepted start.
REQ-008 thresh  in  W  maximum allowed |ones-zeros|; latched on an accepted start.
REQ-009 ones, zeros  in  W each  tallies from the bit counter.
REQ-010 lfsr_q  in  W  current LFSR state, used only by the REQ-031 feature.
REQ-011 cnt_clr  out  1  one-cycle clear pulse to the bit counter.
REQ-012 lfsr_load  out  1  one-cycle seed-load pulse to the LFSR.
REQ-013 seed_out  out  W  latched seed, valid while lfsr_load is high.
REQ-014 sh_en  out  1  shift enable shared by the LFSR and the counter.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 total  out  W+1  ones+zeros, captured at DONE.
REQ-018 diff  out  W  |ones-zeros|, captured at DONE.
REQ-019 pass  out  1  diff<=thresh, captured at DONE.
REQ-020 period  out  W  measured LFSR period, per REQ-031.
REQ-021 period_hit  out  1  a period was detected, per REQ-031.

Function
REQ-022 The FSM states shall be IDLE, CLEAR, LOAD, RUN, SETTLE and DONE, with registered Moore outputs.
- IDLE->CLEAR: start=1 in IDLE; the input latches are loaded on the same edge.
- CLEAR->LOAD: unconditional; cnt_clr=1 in CLEAR.
- LOAD->RUN if run_len!=0, else LOAD->SETTLE; lfsr_load=1 in LOAD.
- RUN: sh_en=1 for exactly run_len cycles, timed by an internal W-bit down-counter; then ->SETTLE.
- SETTLE->DONE: sh_en=0, one cycle for the counter to settle.
- DONE->IDLE: done=1; result registers are captured.
REQ-023 Latency: with start sampled at edge 0, done shall be high during cycle run_len+4, and sh_en shall be high in cycles 3..run_len+2.
REQ-024 Arithmetic: total shall be the zero-extended W+1-bit sum, and diff shall be the larger tally minus the smaller.
REQ-025 start shall be ignored while busy=1, with no queuing.
REQ-026 abort=1 in any busy state shall force IDLE on the next edge, with sh_en, cnt_clr and lfsr_load low, no done pulse, and all result registers unchanged.
REQ-027 abort shall take priority over start when both are high in IDLE, so no run begins.
REQ-028 With run_len=0, sh_en shall never assert, done shall occur in cycle 4, and the results shall be total=0, diff=0, pass=1.
REQ-029 run_len=2^W-1 shall run to completion without down-counter wrap.
REQ-030 total, diff, pass, period and period_hit shall hold their values until the next DONE or reset.

Configuration
REQ-031 The macro LFSR_RUN_PERIOD_CHECK_EN shall control period detection.
- Defined: in RUN, on the first cycle after at least one shift where lfsr_q==latched seed, period=shifts issued and period_hit=1. Only the first hit is recorded, and the run continues to run_len. Both outputs are cleared in CLEAR.
- Undefined: period=0 and period_hit=0 constantly, lfsr_q is ignored, and no comparator logic is built.

Reset
REQ-032 On reset, the block shall enter IDLE with cnt_clr, lfsr_load, sh_en, busy, done, pass and period_hit at 0, and seed_out, total, diff, period and all internal registers at 0.
REQ-033 Reset mid-run shall abort immediately without a done pulse, and operation shall resume on the first clk edge after reset deasserts.

Verification
REQ-034 The bench shall cover these directed scenarios.
- seed=16'hACE1, run_len=100, thresh=20, modelled LFSR+counter -> sh_en high exactly 100 cycles, done at cycle 104, total=100, pass=(diff<=20).
- run_len=0, start -> no sh_en, done at cycle 4, total=0, diff=0, pass=1.
- start pulsed during RUN -> ignored; a single done occurs.
- abort in cycle 10 of a run_len=50 run -> IDLE next edge, no done, prior results held.
- reset asserted during RUN -> all outputs 0 asynchronously; a subsequent start completes normally.
- With LFSR_RUN_PERIOD_CHECK_EN, maximal 4-bit-style LFSR model (period 15), run_len=40 -> period=15, period_hit=1; without the macro, both stay 0.

Source files
------------

// File: rtl/lfsr_run_if.sv
// Handshake/data bundle between the LFSR run controller and its LFSR, bit counter and host.
// The master side drives run requests and tallies; the slave side is the controller.
interface lfsr_run_if #(parameter int W = 16);
    logic         start;
    logic         abort;
    logic [W-1:0] seed;
    logic [W-1:0] run_len;
    logic [W-1:0] thresh;
    logic [W-1:0] ones;
    logic [W-1:0] zeros;
    logic [W-1:0] lfsr_q;
    logic         cnt_clr;
    logic         lfsr_load;
    logic [W-1:0] seed_out;
    logic         sh_en;
    logic         busy;
    logic         done;
    logic [W:0]   total;
    logic [W-1:0] diff;
    logic         pass;
    logic [W-1:0] period;
    logic         period_hit;

    modport master (
        output start, abort, seed, run_len, thresh, ones, zeros, lfsr_q,
        input  cnt_clr, lfsr_load, seed_out, sh_en, busy, done,
               total, diff, pass, period, period_hit
    );

    modport slave (
        input  start, abort, seed, run_len, thresh, ones, zeros, lfsr_q,
        output cnt_clr, lfsr_load, seed_out, sh_en, busy, done,
               total, diff, pass, period, period_hit
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// LFSR test-run controller: clears the counter, loads the seed, shifts run_len times and grades balance.
// Optional period detection is built only when LFSR_RUN_PERIOD_CHECK_EN is defined.
module lfsr_run_ctrl #(
    parameter int W = 16
) (
    input  logic       clk,
    input  logic       reset,
    lfsr_run_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_seed;
    logic [W-1:0] r_len;
    logic [W-1:0] r_thresh;
    logic [W-1:0] r_cnt;
    logic         r_cnt_clr;
    logic         r_lfsr_load;
    logic         r_sh_en;
    logic         r_busy;
    logic         r_done;
    logic [W:0]   r_total;
    logic [W-1:0] r_diff;
    logic         r_pass;

    logic [W:0]   w_total;
    logic [W-1:0] w_diff;

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [W:0] sum_ext(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign w_total = sum_ext(bus.ones, bus.zeros);
    assign w_diff  = abs_diff(bus.ones, bus.zeros);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_seed      <= '0;
            r_len       <= '0;
            r_thresh    <= '0;
            r_cnt       <= '0;
            r_cnt_clr   <= 1'b0;
            r_lfsr_load <= 1'b0;
            r_sh_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_total     <= '0;
            r_diff      <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_cnt_clr   <= 1'b0;
            r_lfsr_load <= 1'b0;
            r_done      <= 1'b0;
            // Abort wins over every transition, including result capture in SETTLE.
            if (r_state != S_IDLE && bus.abort) begin
                r_state <= S_IDLE;
                r_sh_en <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            r_seed    <= bus.seed;
                            r_len     <= bus.run_len;
                            r_thresh  <= bus.thresh;
                            r_state   <= S_CLEAR;
                            r_cnt_clr <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        r_state     <= S_LOAD;
                        r_lfsr_load <= 1'b1;
                    end
                    S_LOAD: begin
                        if (r_len != '0) begin
                            r_state <= S_RUN;
                            r_sh_en <= 1'b1;
                            r_cnt   <= r_len;
                        end else begin
                            r_state <= S_SETTLE;
                        end
                    end
                    S_RUN: begin
                        // Exit on 1 rather than 0 so run_len = all-ones never wraps.
                        if (r_cnt == W'(1)) begin
                            r_state <= S_SETTLE;
                            r_sh_en <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - W'(1);
                        end
                    end
                    S_SETTLE: begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_total <= w_total;
                        r_diff  <= w_diff;
                        r_pass  <= (w_diff <= r_thresh);
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_sh_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_RUN_PERIOD_CHECK_EN
    logic [W-1:0] r_shifts;
    logic [W-1:0] r_period;
    logic         r_period_hit;
    logic         w_seed_match;

    assign w_seed_match = (bus.lfsr_q == r_seed);

    // r_shifts counts shifts already applied, so it equals the period on the first return to the seed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shifts     <= '0;
            r_period     <= '0;
            r_period_hit <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_shifts     <= '0;
            r_period     <= '0;
            r_period_hit <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_shifts <= r_shifts + W'(1);
            if (!r_period_hit && r_shifts != '0 && w_seed_match) begin
                r_period     <= r_shifts;
                r_period_hit <= 1'b1;
            end
        end
    end

    assign bus.period     = r_period;
    assign bus.period_hit = r_period_hit;
`else
    logic w_unused_lfsr_q;
    assign w_unused_lfsr_q = ^bus.lfsr_q;

    assign bus.period     = '0;
    assign bus.period_hit = 1'b0;
`endif

    assign bus.cnt_clr   = r_cnt_clr;
    assign bus.lfsr_load = r_lfsr_load;
    assign bus.seed_out  = r_seed;
    assign bus.sh_en     = r_sh_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.total     = r_total;
    assign bus.diff      = r_diff;
    assign bus.pass      = r_pass;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Directed bench for lfsr_run_ctrl with behavioural LFSR and bit-counter models around it.
// Period expectations follow LFSR_RUN_PERIOD_CHECK_EN.
module tb_lfsr_run_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lfsr_run_if #(.W(W)) bus ();
    lfsr_run_ctrl #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // LFSR and bit-counter models; m_mode4 selects a 4-bit maximal LFSR (period 15).
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_ones = '0;
    logic [W-1:0] m_zeros = '0;
    logic         m_mode4 = 1'b0;

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] q, input logic mode4);
        if (mode4) return {12'b0, q[2:0], q[3] ^ q[2]};
        return {1'b0, q[W-1:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        if (bus.lfsr_load)  m_q <= bus.seed_out;
        else if (bus.sh_en) m_q <= lfsr_next(m_q, m_mode4);
        if (bus.cnt_clr) begin
            m_ones  <= '0;
            m_zeros <= '0;
        end else if (bus.sh_en) begin
            if (m_q[0]) m_ones  <= m_ones + 1'b1;
            else        m_zeros <= m_zeros + 1'b1;
        end
    end

    assign bus.lfsr_q = m_q;
    assign bus.ones   = m_ones;
    assign bus.zeros  = m_zeros;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-run observations, cycle c = interval following edge c-1 (start sampled at edge 0).
    int           o_done_first, o_done_n, o_sh_n, o_sh_first, o_sh_last, o_clr_cyc, o_load_cyc;
    logic [W-1:0] o_seed_load;
    logic         o_busy [0:255];
    logic         o_sh   [0:255];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_watch(input int ncyc, input int pulse_at, input int abort_at);
        o_done_first = -1; o_done_n = 0; o_sh_n = 0; o_sh_first = -1; o_sh_last = -1;
        o_clr_cyc = -1; o_load_cyc = -1; o_seed_load = '0;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            bus.start = (c == pulse_at);
            bus.abort = (c == abort_at);
            o_busy[c] = bus.busy;
            o_sh[c]   = bus.sh_en;
            if (bus.done) begin
                o_done_n++;
                if (o_done_first < 0) o_done_first = c;
            end
            if (bus.sh_en) begin
                o_sh_n++;
                if (o_sh_first < 0) o_sh_first = c;
                o_sh_last = c;
            end
            if (bus.cnt_clr && o_clr_cyc < 0) o_clr_cyc = c;
            if (bus.lfsr_load && o_load_cyc < 0) begin
                o_load_cyc  = c;
                o_seed_load = bus.seed_out;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    function automatic logic [W-1:0] model_diff();
        return (m_ones >= m_zeros) ? m_ones - m_zeros : m_zeros - m_ones;
    endfunction

    logic [W-1:0] e_diff;
    logic         e_pass;
    logic [W:0]   e_total;
    logic [W-1:0] e_period;
    logic         e_hit;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.seed = '0; bus.run_len = '0; bus.thresh = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {bus.busy, bus.done, bus.cnt_clr, bus.lfsr_load, bus.sh_en, bus.pass, bus.period_hit}, 7'b0);
        chk("rst_data", {bus.seed_out, bus.total, bus.diff, bus.period}, 65'b0);
        reset = 1'b0;

        // Abort together with start in IDLE: nothing begins.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", bus.busy, 1'b0);
        bus.abort = 1'b0;
        bus.start = 1'b0;

        // Long run with the 16-bit LFSR.
        m_mode4 = 1'b0;
        bus.seed = 16'hACE1; bus.run_len = 16'd100; bus.thresh = 16'd20;
        run_watch(110, -1, -1);
        chk("r100_clr_cyc",  o_clr_cyc, 1);
        chk("r100_load_cyc", o_load_cyc, 2);
        chk("r100_seed_out", o_seed_load, 16'hACE1);
        chk("r100_sh_n",     o_sh_n, 100);
        chk("r100_sh_first", o_sh_first, 3);
        chk("r100_sh_last",  o_sh_last, 102);
        chk("r100_done_cyc", o_done_first, 104);
        chk("r100_done_n",   o_done_n, 1);
        chk("r100_busy_end", {o_busy[104], o_busy[105]}, 2'b10);
        e_diff = model_diff();
        e_pass = (e_diff <= 16'd20);
        chk("r100_total", bus.total, 17'd100);
        chk("r100_diff",  bus.diff, e_diff);
        chk("r100_pass",  bus.pass, e_pass);
        chk("r100_period", {bus.period_hit, bus.period}, 17'd0);

        // Zero-length run.
        bus.seed = 16'h5A5A; bus.run_len = 16'd0; bus.thresh = 16'd0;
        run_watch(10, -1, -1);
        chk("r0_sh_n",     o_sh_n, 0);
        chk("r0_done_cyc", o_done_first, 4);
        chk("r0_done_n",   o_done_n, 1);
        chk("r0_results",  {bus.total, bus.diff, bus.pass}, {17'd0, 16'd0, 1'b1});

        // Start pulsed mid-run with different inputs is ignored, not queued.
        bus.seed = 16'h1357; bus.run_len = 16'd10; bus.thresh = 16'd10;
        run_watch(40, 6, -1);
        chk("r10_done_cyc", o_done_first, 14);
        chk("r10_done_n",   o_done_n, 1);
        chk("r10_sh_n",     o_sh_n, 10);
        chk("r10_total",    bus.total, 17'd10);
        e_diff = model_diff();
        e_pass = (e_diff <= 16'd10);
        chk("r10_diff", bus.diff, e_diff);

        // Abort during cycle 10 of a 50-shift run: results from the previous run stay.
        bus.seed = 16'hBEEF; bus.run_len = 16'd50; bus.thresh = 16'd0;
        run_watch(70, -1, 10);
        chk("ab_busy_10_11", {o_busy[10], o_busy[11]}, 2'b10);
        chk("ab_sh_10_11",   {o_sh[10], o_sh[11]}, 2'b10);
        chk("ab_sh_n",       o_sh_n, 8);
        chk("ab_done_n",     o_done_n, 0);
        chk("ab_held", {bus.total, bus.diff, bus.pass}, {17'd10, e_diff, e_pass});

        // Reset asserted mid-run clears everything at once.
        bus.seed = 16'h0F0F; bus.run_len = 16'd30; bus.thresh = 16'd30;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("mid_sh_before_rst", bus.sh_en, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ctrl", {bus.busy, bus.done, bus.cnt_clr, bus.lfsr_load, bus.sh_en, bus.pass, bus.period_hit}, 7'b0);
        chk("mid_rst_data", {bus.seed_out, bus.total, bus.diff, bus.period}, 65'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.seed = 16'h1234; bus.run_len = 16'd5; bus.thresh = 16'd5;
        run_watch(15, -1, -1);
        chk("post_rst_done_cyc", o_done_first, 9);
        chk("post_rst_done_n",   o_done_n, 1);
        chk("post_rst_total",    bus.total, 17'd5);

        // Period detection with the 4-bit maximal LFSR (1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1).
        m_mode4 = 1'b1;
        bus.seed = 16'h0001; bus.run_len = 16'd40; bus.thresh = 16'd40;
        run_watch(50, -1, -1);
        chk("p40_done_cyc", o_done_first, 44);
        chk("p40_total",    bus.total, 17'd40);
`ifdef LFSR_RUN_PERIOD_CHECK_EN
        e_period = 16'd15;
        e_hit    = 1'b1;
`else
        e_period = 16'd0;
        e_hit    = 1'b0;
`endif
        chk("p40_period",     bus.period, e_period);
        chk("p40_period_hit", bus.period_hit, e_hit);

        // Period outputs hold while idle.
        repeat (3) @(negedge clk);
        chk("p40_period_hold", {bus.period_hit, bus.period}, {e_hit, e_period});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
